frame_minmax_scanner: RTL and testbench
=======================================

FRAME_MINMAX_SCANNER -- requirements
Module: frame_minmax_scanner

Interface
REQ-001 SHALL have parameter DATAW, default 16: raw pixel width, signed two's complement.
REQ-002 SHALL have parameter MAX_ADDR, default 768: pixels per frame (32x24 sensor).
REQ-003 SHALL have localparam ADDRW = $clog2(MAX_ADDR).
REQ-004 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  scan request, sampled in IDLE only.
REQ-007 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port o_rd_valid  out  1  frame-buffer read strobe.
REQ-009 SHALL have port o_rd_addr  out  ADDRW  frame-buffer read address.
REQ-010 SHALL have port i_rd_data  in  DATAW  signed read data, valid exactly one cycle after its o_rd_valid.
REQ-011 SHALL have port o_done  out  1  one-cycle pulse marking new stats; this pulse drives data_normalizer i_start.
REQ-012 SHALL have ports o_min, o_max, o_range  out  DATAW  signed frame statistics; o_min/o_range feed data_normalizer i_min/i_range.

Function
REQ-013 SHALL implement states IDLE, SCAN, DRAIN, FINISH.
REQ-014 IDLE -> SCAN when i_start=1; i_start SHALL be ignored in every other state.
REQ-015 SCAN SHALL assert o_rd_valid with o_rd_addr = 0,1,...,MAX_ADDR-1 on consecutive cycles, one address per cycle, no gaps.
REQ-016 SCAN -> DRAIN in the cycle after address MAX_ADDR-1 is issued; DRAIN lasts one cycle, capturing the final sample; DRAIN -> FINISH.
REQ-017 o_rd_valid SHALL be 0 and o_rd_addr SHALL hold 0 outside SCAN.
REQ-018 The first sample of a scan SHALL initialise the running min and max; each later sample SHALL update them by signed compare.
REQ-019 FINISH SHALL register o_min, o_max and o_range = o_max - o_min, computed at DATAW+1 bits, for one cycle, pulse o_done, then return to IDLE.
REQ-020 If the difference exceeds 2^(DATAW-1)-1, o_range SHALL saturate to 2^(DATAW-1)-1.
REQ-021 If max == min, o_range SHALL be 1 (no divide-by-zero downstream).
REQ-022 o_done SHALL rise exactly MAX_ADDR+3 cycles after the edge that sampled i_start=1.
REQ-023 o_min/o_max/o_range SHALL hold their last published values until the next FINISH; partial scan results SHALL never appear on them.
REQ-024 o_done SHALL never be high for two consecutive cycles.

Reset
REQ-025 i_rst_n=0 SHALL asynchronously force state IDLE and clear all outputs (o_busy, o_rd_valid, o_rd_addr, o_done, o_min, o_max, o_range) and the internal address counter to 0.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no o_done pulse; after release, the block SHALL accept a new i_start normally.

Structure
REQ-027 The state enum and a packed stats struct {min, max, range} SHALL live in shared package frame_stats_pkg.
REQ-028 The block SHALL be a single module: a two-process (registered struct plus combinational next) FSM with no sub-module.
REQ-029 Saturation and zero-range logic SHALL be a package function, so that data_normalizer can reuse it.

Verification (bench MAX_ADDR=20, DATAW=16, 1-cycle RAM model)
REQ-030 Ramp -5..14 at addr 0..19, pulse start -> o_done at cycle 23; o_min=-5, o_max=14, o_range=19.
REQ-031 Constant 7 at all addresses -> o_min=7, o_max=7, o_range=1.
REQ-032 Addr 3 = -32768, addr 17 = 32767, others 0 -> o_min=-32768, o_max=32767, o_range=32767 (saturated).
REQ-033 i_start held high throughout one scan -> exactly 20 reads per scan, one o_done per scan; re-scan starts only after return to IDLE.
REQ-034 i_rst_n pulsed low at addr 10 -> outputs 0 immediately, no o_done; a following full scan of the ramp gives the REQ-030 result.
REQ-035 Chained into data_normalizer with ramp 0..19 -> normalizer writes o_wr_data = (scale*addr)>>FRACTIONW for all 20 addresses.

Source files
------------

// File: rtl/frame_stats_pkg.sv
// Shared definitions for the frame statistics path.
// Holds the scanner state encoding, the packed statistics record published
// at the end of each frame, and the range helper that both the scanner and
// the downstream normalizer use, so they agree on saturation and on the
// zero-range substitute.
package frame_stats_pkg;

  // Pixel width the statistics record is built for. Blocks that carry these
  // stats use this width for their data path.
  localparam int PIXW = 16;

  // Largest positive value representable at PIXW bits, held at PIXW+1 bits
  // so it can be compared against a widened difference.
  localparam logic signed [PIXW:0] RANGE_MAX = {2'b00, {(PIXW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic signed [PIXW-1:0] min_val;
    logic signed [PIXW-1:0] max_val;
    logic signed [PIXW-1:0] range_val;
  } stats_t;

  // max - min evaluated one bit wider so it cannot wrap. A flat frame gives
  // 1 so a divider downstream never sees zero; a spread wider than the
  // positive range clamps to the largest positive value.
  function automatic logic signed [PIXW-1:0] range_sat(
    input logic signed [PIXW-1:0] min_in,
    input logic signed [PIXW-1:0] max_in
  );
    logic signed [PIXW:0] diff;
    diff = {max_in[PIXW-1], max_in} - {min_in[PIXW-1], min_in};
    if (diff == '0) begin
      return {{(PIXW-1){1'b0}}, 1'b1};
    end else if (diff > RANGE_MAX) begin
      return RANGE_MAX[PIXW-1:0];
    end else begin
      return diff[PIXW-1:0];
    end
  endfunction

endpackage

// File: rtl/frame_minmax_scanner.sv
// Frame min/max scanner.
// On a start request, reads every pixel of a frame buffer in address order,
// tracks the signed minimum and maximum, and publishes min, max and a
// saturated range together with a one-cycle done pulse.
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     scan request, only looked at while idle
//   o_busy      high whenever a scan is in progress
//   o_rd_valid  frame-buffer read strobe
//   o_rd_addr   frame-buffer read address
//   i_rd_data   signed read data, valid the cycle after its strobe
//   o_done      one-cycle pulse when new statistics are published
//   o_min       published frame minimum
//   o_max       published frame maximum
//   o_range     published max - min, saturated, never zero
module frame_minmax_scanner
  import frame_stats_pkg::*;
#(
  parameter int DATAW    = 16,
  parameter int MAX_ADDR = 768
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_rd_valid,
  output logic [$clog2(MAX_ADDR)-1:0] o_rd_addr,
  input  logic signed [DATAW-1:0] i_rd_data,
  output logic                    o_done,
  output logic signed [DATAW-1:0] o_min,
  output logic signed [DATAW-1:0] o_max,
  output logic signed [DATAW-1:0] o_range
);

  localparam int ADDRW = $clog2(MAX_ADDR);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(MAX_ADDR - 1);

  // All state of the block lives in one record so reset and update are
  // a single assignment each.
  typedef struct packed {
    scan_state_e              state;
    logic [ADDRW-1:0]         addr;
    logic                     rd_valid;
    logic                     sample_valid;
    logic                     first;
    logic signed [DATAW-1:0]  run_min;
    logic signed [DATAW-1:0]  run_max;
    stats_t                   stats;
    logic                     done;
  } regs_t;

  regs_t regs_q, regs_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    regs_d              = regs_q;
    regs_d.done         = 1'b0;
    // Read data arrives one cycle after its strobe, so a delayed copy of
    // the strobe marks which cycles carry a pixel.
    regs_d.sample_valid = regs_q.rd_valid;

    // The running min/max only ever live here; the published record is
    // touched solely in FINISH so partial results never leak out.
    if (regs_q.sample_valid) begin
      if (regs_q.first) begin
        regs_d.run_min = i_rd_data;
        regs_d.run_max = i_rd_data;
        regs_d.first   = 1'b0;
      end else begin
        if (i_rd_data < regs_q.run_min) begin
          regs_d.run_min = i_rd_data;
        end
        if (i_rd_data > regs_q.run_max) begin
          regs_d.run_max = i_rd_data;
        end
      end
    end

    case (regs_q.state)
      IDLE: begin
        if (i_start) begin
          regs_d.state = SCAN;
          regs_d.first = 1'b1;
        end
      end
      SCAN: begin
        // First SCAN cycle raises the strobe at address 0; afterwards the
        // address steps every cycle until the last one has been issued.
        regs_d.rd_valid = 1'b1;
        if (regs_q.rd_valid) begin
          if (regs_q.addr == LAST_ADDR) begin
            regs_d.state    = DRAIN;
            regs_d.rd_valid = 1'b0;
            regs_d.addr     = '0;
          end else begin
            regs_d.addr = regs_q.addr + ADDRW'(1);
          end
        end
      end
      DRAIN: begin
        regs_d.state = FINISH;
      end
      FINISH: begin
        regs_d.stats.min_val   = regs_q.run_min;
        regs_d.stats.max_val   = regs_q.run_max;
        regs_d.stats.range_val = range_sat(regs_q.run_min, regs_q.run_max);
        regs_d.done            = 1'b1;
        regs_d.state           = IDLE;
      end
      default: begin
        regs_d.state = IDLE;
      end
    endcase
  end

  assign o_busy     = (regs_q.state != IDLE);
  assign o_rd_valid = regs_q.rd_valid;
  assign o_rd_addr  = regs_q.addr;
  assign o_done     = regs_q.done;
  assign o_min      = regs_q.stats.min_val;
  assign o_max      = regs_q.stats.max_val;
  assign o_range    = regs_q.stats.range_val;

endmodule

// File: tb/tb_frame_minmax_scanner.sv
// Self-checking bench for frame_minmax_scanner with a 20-pixel frame and a
// one-cycle-latency frame-buffer model.
module tb_frame_minmax_scanner;

  localparam int DATAW    = 16;
  localparam int MAX_ADDR = 20;
  localparam int ADDRW    = $clog2(MAX_ADDR);

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    busy;
  logic                    rd_valid;
  logic [ADDRW-1:0]        rd_addr;
  logic signed [DATAW-1:0] rd_data;
  logic                    done;
  logic signed [DATAW-1:0] o_min;
  logic signed [DATAW-1:0] o_max;
  logic signed [DATAW-1:0] o_range;

  logic signed [DATAW-1:0] mem [0:MAX_ADDR-1];

  int tests_run    = 0;
  int tests_failed = 0;

  int rd_addrs [$];
  int done_count  = 0;
  int consec_done = 0;
  logic prev_done = 1'b0;

  frame_minmax_scanner #(
    .DATAW   (DATAW),
    .MAX_ADDR(MAX_ADDR)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .o_busy    (busy),
    .o_rd_valid(rd_valid),
    .o_rd_addr (rd_addr),
    .i_rd_data (rd_data),
    .o_done    (done),
    .o_min     (o_min),
    .o_max     (o_max),
    .o_range   (o_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer: data for a strobed address appears one cycle later.
  always @(posedge clk) begin
    if (rd_valid) rd_data <= mem[rd_addr];
  end

  // Record every read address and every done pulse.
  always @(posedge clk) begin
    if (rd_valid) rd_addrs.push_back(int'(rd_addr));
    if (done) begin
      done_count++;
      if (prev_done) consec_done++;
    end
    prev_done = done;
  end

  // Reference statistics straight from the frame contents.
  task automatic model_frame(output logic signed [15:0] mn, output logic signed [15:0] mx,
                             output logic signed [15:0] rg);
    int a, b, r;
    a = mem[0];
    b = mem[0];
    for (int i = 1; i < MAX_ADDR; i++) begin
      if (int'(mem[i]) < a) a = mem[i];
      if (int'(mem[i]) > b) b = mem[i];
    end
    r = b - a;
    if (r == 0) r = 1;
    else if (r > 32767) r = 32767;
    mn = 16'(a);
    mx = 16'(b);
    rg = 16'(r);
  endtask

  // Pulse start for one edge and count cycles from the sampling edge until
  // done; notes whether the published outputs moved before done.
  task automatic applyStimulus(output int cyc, output int changed);
    logic signed [15:0] pmin, pmax, prng;
    @(negedge clk);
    pmin = o_min; pmax = o_max; prng = o_range;
    rd_addrs.delete();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    changed = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (o_min !== pmin || o_max !== pmax || o_range !== prng) changed = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    #3;
    tests_run++;
    if ({busy, rd_valid, rd_addr, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got busy=%b valid=%b addr=%0d done=%b required all 0",
               busy, rd_valid, rd_addr, done);
    end
    tests_run++;
    if ({o_min, o_max, o_range} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stats: got %0d/%0d/%0d required 0/0/0", o_min, o_max, o_range);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_no_start: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_ramp;
    int cyc, changed, seq_ok;
    for (int i = 0; i < MAX_ADDR; i++) mem[i] = 16'(i - 5);
    applyStimulus(cyc, changed);
    tests_run++;
    if (cyc !== 23) begin
      tests_failed++;
      $display("[TB] FAIL ramp_latency: got %0d cycles required 23", cyc);
    end
    tests_run++;
    if (o_min !== -16'sd5 || o_max !== 16'sd14 || o_range !== 16'sd19) begin
      tests_failed++;
      $display("[TB] FAIL ramp_stats: got %0d/%0d/%0d required -5/14/19", o_min, o_max, o_range);
    end
    tests_run++;
    if (changed !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ramp_partial: got early output change=%0d required 0", changed);
    end
    seq_ok = (rd_addrs.size() == MAX_ADDR);
    for (int i = 0; i < rd_addrs.size() && i < MAX_ADDR; i++)
      if (rd_addrs[i] != i) seq_ok = 0;
    tests_run++;
    if (seq_ok !== 1) begin
      tests_failed++;
      $display("[TB] FAIL ramp_reads: got %0d reads in order=%0d required 20 in order",
               rd_addrs.size(), seq_ok);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL ramp_after: got done=%b busy=%b addr=%0d required 0/0/0",
               done, busy, rd_addr);
    end
  endtask

  task automatic test_constant;
    int cyc, changed;
    for (int i = 0; i < MAX_ADDR; i++) mem[i] = 16'sd7;
    applyStimulus(cyc, changed);
    tests_run++;
    if (o_min !== 16'sd7 || o_max !== 16'sd7 || o_range !== 16'sd1) begin
      tests_failed++;
      $display("[TB] FAIL const_stats: got %0d/%0d/%0d required 7/7/1", o_min, o_max, o_range);
    end
  endtask

  task automatic test_saturate;
    int cyc, changed;
    for (int i = 0; i < MAX_ADDR; i++) mem[i] = '0;
    mem[3]  = -16'sd32768;
    mem[17] = 16'sd32767;
    applyStimulus(cyc, changed);
    tests_run++;
    if (o_min !== -16'sd32768 || o_max !== 16'sd32767 || o_range !== 16'sd32767) begin
      tests_failed++;
      $display("[TB] FAIL sat_stats: got %0d/%0d/%0d required -32768/32767/32767",
               o_min, o_max, o_range);
    end
  endtask

  task automatic test_random;
    int cyc, changed, mode;
    logic signed [15:0] emin, emax, erng;
    for (int f = 0; f < 6; f++) begin
      mode = f % 3;
      for (int i = 0; i < MAX_ADDR; i++) begin
        if (mode == 0)      mem[i] = 16'($urandom);
        else if (mode == 1) mem[i] = 16'(int'($urandom_range(6)) - 3);
        else                mem[i] = 16'(int'($urandom_range(2000)) - 1000);
      end
      model_frame(emin, emax, erng);
      applyStimulus(cyc, changed);
      tests_run++;
      if (cyc !== 23 || o_min !== emin || o_max !== emax || o_range !== erng) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: got cyc=%0d %0d/%0d/%0d required 23 %0d/%0d/%0d",
                 f, cyc, o_min, o_max, o_range, emin, emax, erng);
      end
    end
  endtask

  // Start held high: each scan takes 24 cycles (23 to done plus one idle
  // cycle to resample start), so dones land at cycles 23 and 47.
  task automatic test_back_to_back;
    int ndone, hit23, hit47;
    for (int i = 0; i < MAX_ADDR; i++) mem[i] = 16'(3 * i - 20);
    @(negedge clk);
    rd_addrs.delete();
    start = 1'b1;
    @(posedge clk);
    ndone = 0; hit23 = 0; hit47 = 0;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (c == 23) hit23 = 1;
        if (c == 47) hit47 = 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (ndone !== 2 || hit23 !== 1 || hit47 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL held_done: got %0d dones (c23=%0d c47=%0d) required 2 at 23,47",
               ndone, hit23, hit47);
    end
    tests_run++;
    if (rd_addrs.size() !== 2 * MAX_ADDR) begin
      tests_failed++;
      $display("[TB] FAIL held_reads: got %0d reads required %0d", rd_addrs.size(), 2 * MAX_ADDR);
    end
    tests_run++;
    if (o_min !== -16'sd20 || o_max !== 16'sd37 || o_range !== 16'sd57) begin
      tests_failed++;
      $display("[TB] FAIL held_stats: got %0d/%0d/%0d required -20/37/57", o_min, o_max, o_range);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL held_release: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_scan;
    int cyc, changed, seen, dc;
    for (int i = 0; i < MAX_ADDR; i++) mem[i] = 16'(i - 5);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (rd_valid && rd_addr == 10) seen = 1;
    end
    tests_run++;
    if (seen !== 1) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach_addr10: got seen=%0d required 1", seen);
    end
    #2 rst_n = 1'b0;
    dc = done_count;
    #1;
    tests_run++;
    if ({busy, rd_valid, rd_addr, done, o_min, o_max, o_range} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_clear: got busy=%b valid=%b addr=%0d done=%b %0d/%0d/%0d required all 0",
               busy, rd_valid, rd_addr, done, o_min, o_max, o_range);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    tests_run++;
    if (done_count !== dc || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_done: got %0d extra dones busy=%b required 0/0",
               done_count - dc, busy);
    end
    applyStimulus(cyc, changed);
    tests_run++;
    if (cyc !== 23 || o_min !== -16'sd5 || o_max !== 16'sd14 || o_range !== 16'sd19) begin
      tests_failed++;
      $display("[TB] FAIL abort_rescan: got cyc=%0d %0d/%0d/%0d required 23 -5/14/19",
               cyc, o_min, o_max, o_range);
    end
  endtask

  task automatic checkOutput;
    repeat (2) @(negedge clk);
    tests_run++;
    if (consec_done !== 0) begin
      tests_failed++;
      $display("[TB] FAIL done_width: got %0d back-to-back done cycles required 0", consec_done);
    end
  endtask

  initial begin
    rd_data = '0;
    test_reset();
    test_ramp();
    test_constant();
    test_saturate();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    checkOutput();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
